// File: rtl/vector_load_unpacker.sv
// ---------------------------------------------------------------------------
// vector_load_unpacker
//
// Read side of the vector memory path. One accepted load request issues a
// single 128-bit read, waits MEM_LATENCY cycles, captures the returned word
// and presents it as sixteen registered byte lanes to the vector register
// writeback stage through a valid/ready handshake.
// Lane 1 is bits [127:120] and lane 16 is bits [7:0], which is the inverse of
// the store packer's ordering.
//
// Parameters:
//   ADDR_W      - memory address width
//   MEM_LATENCY - cycles from the mem_rd_en cycle to valid mem_rdata (1..15)
//
// Ports:
//   clk, rst                  - clock, asynchronous active-high reset
//   load_start, load_addr     - load request and its address
//   load_busy                 - a load_start this cycle would be rejected
//   load_err                  - one-cycle pulse after a rejected load_start
//   mem_rd_en, mem_addr       - one-cycle read strobe and registered address
//   mem_rdata                 - read data from memory
//   lane_valid, lane_ready    - handshake towards writeback
//   vector_lane_1_mem..16_mem - unpacked byte lanes
//
// Optional feature, macro VLOAD_SCALAR_EXTRACT_EN:
//   lane_sel[3:0]    - lane select, sampled with an accepted load_start
//   scalar_lane[7:0] - copy of lane lane_sel+1, loaded at capture time
// ---------------------------------------------------------------------------
module vector_load_unpacker #(
    parameter int ADDR_W      = 32,
    parameter int MEM_LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic [ADDR_W-1:0] load_addr,
    output logic              load_busy,
    output logic              load_err,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [127:0]      mem_rdata,
    output logic              lane_valid,
    input  logic              lane_ready,
    output logic [7:0]        vector_lane_1_mem,
    output logic [7:0]        vector_lane_2_mem,
    output logic [7:0]        vector_lane_3_mem,
    output logic [7:0]        vector_lane_4_mem,
    output logic [7:0]        vector_lane_5_mem,
    output logic [7:0]        vector_lane_6_mem,
    output logic [7:0]        vector_lane_7_mem,
    output logic [7:0]        vector_lane_8_mem,
    output logic [7:0]        vector_lane_9_mem,
    output logic [7:0]        vector_lane_10_mem,
    output logic [7:0]        vector_lane_11_mem,
    output logic [7:0]        vector_lane_12_mem,
    output logic [7:0]        vector_lane_13_mem,
    output logic [7:0]        vector_lane_14_mem,
    output logic [7:0]        vector_lane_15_mem,
    output logic [7:0]        vector_lane_16_mem
`ifdef VLOAD_SCALAR_EXTRACT_EN
    ,
    input  logic [3:0]        lane_sel,
    output logic [7:0]        scalar_lane
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [3:0] LAT = 4'(MEM_LATENCY);

    state_t     state;
    logic [3:0] cnt;
    logic [7:0] lanes [16];

`ifdef VLOAD_SCALAR_EXTRACT_EN
    logic [3:0] sel_q;
`endif

    // A request is refused while a read is outstanding, or while captured
    // lanes are still waiting for writeback and writeback is not taking them
    // this cycle. A HOLD cycle with lane_ready high frees the slot, which is
    // what allows a new load to start in the handshake cycle.
    assign load_busy = (state == WAIT) | ((state == HOLD) & ~lane_ready);

    // Single state machine owning every registered output. The read strobe
    // defaults low each cycle so it can never stay high for two cycles.
    // The counter is loaded with the full latency on issue and the word is
    // taken once it reaches zero, which lands the capture at the end of cycle
    // 1+MEM_LATENCY when counting the request cycle as cycle 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            mem_rd_en  <= 1'b0;
            mem_addr   <= '0;
            lane_valid <= 1'b0;
            load_err   <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                lanes[i] <= 8'h00;
            end
`ifdef VLOAD_SCALAR_EXTRACT_EN
            sel_q       <= 4'd0;
            scalar_lane <= 8'h00;
`endif
        end else begin
            mem_rd_en <= 1'b0;
            load_err  <= load_start & load_busy;

            case (state)
                IDLE: begin
                    if (load_start) begin
                        mem_rd_en <= 1'b1;
                        mem_addr  <= load_addr;
                        cnt       <= LAT;
                        state     <= WAIT;
`ifdef VLOAD_SCALAR_EXTRACT_EN
                        sel_q     <= lane_sel;
`endif
                    end
                end

                WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        for (int i = 0; i < 16; i++) begin
                            lanes[i] <= mem_rdata[8*(15-i) +: 8];
                        end
`ifdef VLOAD_SCALAR_EXTRACT_EN
                        // ~sel_q equals 15-sel_q, so this picks lane sel_q+1
                        scalar_lane <= mem_rdata[{~sel_q, 3'b000} +: 8];
`endif
                        lane_valid <= 1'b1;
                        state      <= HOLD;
                    end
                end

                HOLD: begin
                    if (lane_ready) begin
                        lane_valid <= 1'b0;
                        if (load_start) begin
                            mem_rd_en <= 1'b1;
                            mem_addr  <= load_addr;
                            cnt       <= LAT;
                            state     <= WAIT;
`ifdef VLOAD_SCALAR_EXTRACT_EN
                            sel_q     <= lane_sel;
`endif
                        end else begin
                            state <= IDLE;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Lane registers fan out to the individual writeback ports
    assign vector_lane_1_mem  = lanes[0];
    assign vector_lane_2_mem  = lanes[1];
    assign vector_lane_3_mem  = lanes[2];
    assign vector_lane_4_mem  = lanes[3];
    assign vector_lane_5_mem  = lanes[4];
    assign vector_lane_6_mem  = lanes[5];
    assign vector_lane_7_mem  = lanes[6];
    assign vector_lane_8_mem  = lanes[7];
    assign vector_lane_9_mem  = lanes[8];
    assign vector_lane_10_mem = lanes[9];
    assign vector_lane_11_mem = lanes[10];
    assign vector_lane_12_mem = lanes[11];
    assign vector_lane_13_mem = lanes[12];
    assign vector_lane_14_mem = lanes[13];
    assign vector_lane_15_mem = lanes[14];
    assign vector_lane_16_mem = lanes[15];

endmodule

// File: tb/tb_vector_load_unpacker.sv
// ---------------------------------------------------------------------------
// tb_vector_load_unpacker
//
// Transaction-level bench for vector_load_unpacker. Each load is described
// by address, data word, backpressure length and whether a rejected request
// is thrown in during the wait. Expected cycle positions come from the
// documented load timeline and expected lane values from shifting the word.
// The memory side returns the word only in the cycle it is due and random
// data in every other cycle.
// Macro VLOAD_SCALAR_EXTRACT_EN enables the scalar lane ports and checks.
// ---------------------------------------------------------------------------
module tb_vector_load_unpacker;

    localparam int LAT = 2;

    logic         clk;
    logic         rst;
    logic         load_start;
    logic [31:0]  load_addr;
    logic         load_busy;
    logic         load_err;
    logic         mem_rd_en;
    logic [31:0]  mem_addr;
    logic [127:0] mem_rdata;
    logic         lane_valid;
    logic         lane_ready;
    logic [7:0]   laneObs [16];
`ifdef VLOAD_SCALAR_EXTRACT_EN
    logic [3:0]   lane_sel;
    logic [7:0]   scalar_lane;
`endif

    int           testCount;
    int           failCount;
    int           cyc;
    int           dataCycle;
    logic [127:0] dataWord;
    logic [127:0] lastWord;
    logic [127:0] lanesVec;

    vector_load_unpacker #(
        .ADDR_W      (32),
        .MEM_LATENCY (LAT)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .load_start         (load_start),
        .load_addr          (load_addr),
        .load_busy          (load_busy),
        .load_err           (load_err),
        .mem_rd_en          (mem_rd_en),
        .mem_addr           (mem_addr),
        .mem_rdata          (mem_rdata),
        .lane_valid         (lane_valid),
        .lane_ready         (lane_ready),
        .vector_lane_1_mem  (laneObs[0]),
        .vector_lane_2_mem  (laneObs[1]),
        .vector_lane_3_mem  (laneObs[2]),
        .vector_lane_4_mem  (laneObs[3]),
        .vector_lane_5_mem  (laneObs[4]),
        .vector_lane_6_mem  (laneObs[5]),
        .vector_lane_7_mem  (laneObs[6]),
        .vector_lane_8_mem  (laneObs[7]),
        .vector_lane_9_mem  (laneObs[8]),
        .vector_lane_10_mem (laneObs[9]),
        .vector_lane_11_mem (laneObs[10]),
        .vector_lane_12_mem (laneObs[11]),
        .vector_lane_13_mem (laneObs[12]),
        .vector_lane_14_mem (laneObs[13]),
        .vector_lane_15_mem (laneObs[14]),
        .vector_lane_16_mem (laneObs[15])
`ifdef VLOAD_SCALAR_EXTRACT_EN
        ,
        .lane_sel           (lane_sel),
        .scalar_lane        (scalar_lane)
`endif
    );

    // Free-running clock, 10 time units per cycle
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Lanes gathered back into one word, lane 1 in the top byte
    always_comb begin
        lanesVec = '0;
        for (int i = 0; i < 16; i++) begin
            lanesVec = (lanesVec << 8) | 128'(laneObs[i]);
        end
    end

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        testCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s at cycle %0d: got %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    // Advance one cycle and let the memory model present its data
    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
        if (cyc == dataCycle) mem_rdata = dataWord;
        else mem_rdata = {$urandom(), $urandom(), $urandom(), $urandom()};
    endtask

    // Byte k (0-based lane index) of a word under the lane-1-is-MSB ordering
    function automatic logic [7:0] laneOf(input logic [127:0] word, input int k);
        return 8'((word >> (8 * (15 - k))) & 128'hFF);
    endfunction

    task automatic checkLanes(input string tag, input logic [127:0] word);
        int k;
        checkOutput(tag, lanesVec, word);
        k = $urandom_range(0, 15);
        checkOutput({tag, "One"}, 128'(laneObs[k]), 128'(laneOf(word, k)));
    endtask

    task automatic checkScalar(input string tag, input logic [127:0] word, input logic [3:0] sel);
`ifdef VLOAD_SCALAR_EXTRACT_EN
        checkOutput(tag, 128'(scalar_lane), 128'(laneOf(word, int'(sel))));
`endif
    endtask

    task automatic driveSel(input logic [3:0] sel);
`ifdef VLOAD_SCALAR_EXTRACT_EN
        lane_sel = sel;
`endif
    endtask

    // One load from an accepting state (IDLE, or HOLD handshake cycle).
    // Returns in the cycle where the lanes are valid and writeback is about
    // to accept them; the caller either chains another load or goes idle.
    task automatic applyStimulus(input logic [31:0] addr, input logic [127:0] word,
                                 input int stall, input bit probe, input logic [3:0] sel);
        int c0;
        c0        = cyc;
        dataCycle = c0 + 1 + LAT;
        dataWord  = word;
        lastWord  = word;
        load_start = 1'b1;
        load_addr  = addr;
        lane_ready = 1'b1;
        driveSel(sel);
        #1 checkOutput("busyAtStart", load_busy, 0);

        step();
        load_start = 1'b0;
        load_addr  = $urandom();
        lane_ready = 1'($urandom_range(0, 1));
        driveSel(4'($urandom()));
        checkOutput("rdEnPulse", mem_rd_en, 1);
        checkOutput("memAddr", mem_addr, 128'(addr));
        checkOutput("validOffIssue", lane_valid, 0);
        checkOutput("errOffIssue", load_err, 0);
        #1 checkOutput("busyIssue", load_busy, 1);

        for (int k = 2; k <= 1 + LAT; k++) begin
            step();
            load_start = probe && (k == 2);
            load_addr  = $urandom();
            lane_ready = 1'($urandom_range(0, 1));
            driveSel(4'($urandom()));
            checkOutput("rdEnWait", mem_rd_en, 0);
            checkOutput("memAddrWait", mem_addr, 128'(addr));
            checkOutput("validWait", lane_valid, 0);
            checkOutput("errWait", load_err, 128'(probe && (k == 3)));
            #1 checkOutput("busyWait", load_busy, 1);
        end

        step();
        load_start = 1'b0;
        lane_ready = (stall == 0);
        checkOutput("validUp", lane_valid, 1);
        checkOutput("rdEnValid", mem_rd_en, 0);
        checkOutput("errValid", load_err, 128'(probe && (LAT + 2 == 3)));
        checkLanes("lanes", word);
        checkScalar("scalar", word, sel);

        for (int s = 0; s < stall; s++) begin
            lane_ready = 1'b0;
            #1 checkOutput("busyStall", load_busy, 1);
            step();
            lane_ready = (s == stall - 1);
            checkOutput("validStall", lane_valid, 1);
            checkOutput("rdEnStall", mem_rd_en, 0);
            checkOutput("errStall", load_err, 0);
            checkLanes("lanesStall", word);
            checkScalar("scalarStall", word, sel);
        end
    endtask

    // Handshake without a follow-on load, then confirm the idle state
    task automatic finishIdle();
        load_start = 1'b0;
        lane_ready = 1'b1;
        #1 checkOutput("busyHandshake", load_busy, 0);
        step();
        lane_ready = 1'b0;
        checkOutput("validDrop", lane_valid, 0);
        checkOutput("rdEnIdle", mem_rd_en, 0);
        checkLanes("lanesKept", lastWord);
        #1 checkOutput("busyIdle", load_busy, 0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "Valid"}, lane_valid, 0);
        checkOutput({tag, "RdEn"}, mem_rd_en, 0);
        checkOutput({tag, "Addr"}, mem_addr, 0);
        checkOutput({tag, "Err"}, load_err, 0);
        checkOutput({tag, "Lanes"}, lanesVec, 0);
`ifdef VLOAD_SCALAR_EXTRACT_EN
        checkOutput({tag, "Scalar"}, scalar_lane, 0);
`endif
    endtask

    // Reset one cycle after the read strobe; the word arriving afterwards
    // must be ignored and no valid may follow
    task automatic resetMidWait();
        dataCycle  = cyc + 1 + LAT;
        dataWord   = {$urandom(), $urandom(), $urandom(), $urandom()};
        load_start = 1'b1;
        load_addr  = $urandom() | 32'h1;
        lane_ready = 1'b1;
        step();
        load_start = 1'b0;
        checkOutput("rstRdEn", mem_rd_en, 1);
        step();
        rst = 1'b1;
        #1 checkAllZero("rstNow");
        checkOutput("rstBusy", load_busy, 0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            checkOutput("rstNoValid", lane_valid, 0);
            checkOutput("rstNoRdEn", mem_rd_en, 0);
        end
        lastWord = '0;
    endtask

    initial begin
        logic [31:0]  a;
        logic [127:0] w;
        bit           chain;
        testCount  = 0;
        failCount  = 0;
        cyc        = 0;
        dataCycle  = -1;
        dataWord   = '0;
        lastWord   = '0;
        rst        = 1'b1;
        load_start = 1'b0;
        load_addr  = '0;
        lane_ready = 1'b0;
        mem_rdata  = '0;
        driveSel(4'd0);

        step();
        step();
        checkAllZero("reset");
        rst = 1'b0;
        step();

        applyStimulus(32'h40, 128'h00112233445566778899AABBCCDDEEFF, 0, 1'b0, 4'd15);
        finishIdle();
        applyStimulus(32'h1000, 128'h00112233445566778899AABBCCDDEEFF, 2, 1'b0, 4'd0);
        finishIdle();

        applyStimulus($urandom(), {$urandom(), $urandom(), $urandom(), $urandom()}, 5, 1'b0, 4'($urandom()));
        finishIdle();

        applyStimulus($urandom(), {$urandom(), $urandom(), $urandom(), $urandom()}, 1, 1'b0, 4'd3);
        applyStimulus($urandom(), {$urandom(), $urandom(), $urandom(), $urandom()}, 0, 1'b0, 4'd9);
        finishIdle();

        applyStimulus($urandom(), {$urandom(), $urandom(), $urandom(), $urandom()}, 1, 1'b1, 4'd7);
        finishIdle();

        resetMidWait();

        for (int n = 0; n < 30; n++) begin
            a     = $urandom();
            w     = {$urandom(), $urandom(), $urandom(), $urandom()};
            chain = ($urandom_range(0, 2) == 0);
            applyStimulus(a, w, $urandom_range(0, 5), ($urandom_range(0, 3) == 0), 4'($urandom()));
            if (!chain) finishIdle();
        end
        finishIdle();

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/vector_load_unpacker.md
# vector_load_unpacker

Read-side counterpart of the vector store packing path. Issues a single 128-bit vector memory read and waits a fixed memory latency. Captures the returned word and splits it into sixteen registered 8-bit lanes for the vector register writeback stage, handing them off with a valid/ready handshake. Lane ordering is the inverse of the store packer: lane 1 is bits [127:120] and lane 16 is bits [7:0].

## Interface
Parameters:
- ADDR_W, 32, width of the memory address.
- MEM_LATENCY, 2, cycles from the `mem_rd_en` cycle until `mem_rdata` is valid; legal range 1..15.

Ports:
- clk  in  1  system clock. The block has one clock; reset is asynchronous and active-high.
- rst  in  1  asynchronous, active-high reset.
- load_start  in  1  request a vector load, sampled each cycle.
- load_addr  in  ADDR_W  load address, sampled with `load_start`.
- load_busy  out  1  a `load_start` this cycle would be rejected.
- load_err  out  1  one-cycle pulse after a rejected `load_start`.
- mem_rd_en  out  1  one-cycle memory read strobe.
- mem_addr  out  ADDR_W  registered read address.
- mem_rdata  in  128  memory read data.
- lane_valid  out  1  lanes hold a captured word.
- lane_ready  in  1  writeback accepts the lanes.
- vector_lane_1_mem … vector_lane_16_mem  out  8 each  unpacked lanes.

## Operation
- FSM states are IDLE, WAIT and HOLD.
- **IDLE**
  - When `load_start` is high: `mem_rd_en`<=1, `mem_addr`<=`load_addr`, `cnt`<=MEM_LATENCY, next state WAIT.
- **WAIT**
  - `mem_rd_en`<=0.
  - If `cnt`!=0, decrement `cnt`.
  - If `cnt`==0, capture the word: `vector_lane_k_mem` <= `mem_rdata[135-8k -: 8]`, `lane_valid`<=1, next state HOLD.
- **HOLD**
  - `lane_ready`=1: handshake completes and `lane_valid`<=0.
    - If `load_start` is high in the same cycle, issue the new read exactly as from IDLE (next state WAIT).
    - Otherwise, next state IDLE.
  - `lane_ready`=0: hold everything unchanged.
- Lane registers keep their last captured value after a handshake; they are not cleared.
- `load_busy` is combinational: `(state==WAIT) | (state==HOLD & ~lane_ready)`.
- A `load_start` arriving while `load_busy`=1 is dropped: no read is issued and `load_err`=1 in the next cycle only.
- No data transformation: lanes are pure bit slices, with no sign extension or arithmetic.

## Timing
- Cycle 0: `load_start`=1 in IDLE.
- Cycle 1: `mem_rd_en`=1 with `mem_addr` valid.
- `mem_rdata` is sampled at the end of cycle 1+MEM_LATENCY.
- `lane_valid`=1 from cycle 2+MEM_LATENCY, so load-to-valid latency is MEM_LATENCY+2 cycles.
- Back-to-back loads: a new load can start in the handshake cycle. Maximum throughput is one load per MEM_LATENCY+2 cycles.
- `mem_rd_en` is never high for more than one consecutive cycle.
- Reset values: all outputs are 0 (`lane_valid`, `mem_rd_en`, `mem_addr`, all lanes, `load_err`), state is IDLE and `cnt`=0.
- Reset asserted mid-operation aborts immediately. A later in-flight `mem_rdata` is ignored and no `lane_valid` follows.

## Configuration
- Macro `VLOAD_SCALAR_EXTRACT_EN`.
- **Defined:**
  - Adds input `lane_sel[3:0]`, sampled with an accepted `load_start`.
  - Adds output `scalar_lane[7:0]`, loaded at capture with lane `lane_sel+1` (sel 0 = lane 1 = bits [127:120]).
  - `scalar_lane` resets to 0 and is otherwise held.
- **Undefined:** both ports are absent and the behaviour of all other ports is identical.

## Test plan
- **Basic load:** MEM_LATENCY=2, `load_start` with `load_addr`=0x40, `mem_rdata`=0x00112233445566778899AABBCCDDEEFF in cycle 3, `lane_ready`=1.
  - `mem_rd_en` is high in cycle 1 only, with `mem_addr`=0x40.
  - `lane_valid` is high in cycle 4 only.
  - lane 1=0x00, lane 2=0x11, …, lane 16=0xFF.
- **Backpressure:** hold `lane_ready`=0 for 5 cycles after `lane_valid`.
  - `lane_valid` and the lanes stay stable; `load_busy`=1 throughout.
  - Raising `lane_ready` drops `lane_valid` next cycle and returns the FSM to IDLE.
- **Back-to-back:** `load_start` asserted in the same cycle as the HOLD handshake.
  - `mem_rd_en` pulses the next cycle.
  - The second word appears MEM_LATENCY+1 cycles after that pulse with no idle gap.
- **Rejected request:** `load_start` during WAIT.
  - No `mem_rd_en`.
  - `load_err` pulses for one cycle.
  - The original load completes unaffected.
- **Reset mid-WAIT:** assert `rst` one cycle after `mem_rd_en`.
  - All outputs are 0 immediately.
  - Valid `mem_rdata` arriving later does not raise `lane_valid`.
- **Scalar extract** (`VLOAD_SCALAR_EXTRACT_EN`): `lane_sel`=15 with the word from the basic-load case gives `scalar_lane`=0xFF; `lane_sel`=0 gives 0x00.
